tag_hex_display_ctrl: RTL and testbench

//  Avalon-MM master that shares one 7-segment hex PIO slave (7-bit active-low segment

---
 rtl/tag_hex_display_ctrl.sv | 163 ++++++++++++++++
 tb/tb_tag_hex_display_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tag_hex_display_ctrl
// Brief    : Round-robin Avalon-MM writer sharing one 7-segment hex PIO
//            between NUM_REQ requesters, with a per-digit display hold.
// Revision : 1.0
// ============================================================================
module tag_hex_display_ctrl #(
    parameter int NUM_REQ     = 3,
    parameter int HOLD_CYCLES = 25000000,
    parameter int OWNER_W     = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [4*NUM_REQ-1:0] req_digit,
    input  logic [NUM_REQ-1:0]   req_blank,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [1:0]           av_address,
    output logic                 av_chipselect,
    output logic                 av_write_n,
    output logic [31:0]          av_writedata,
    input  logic                 av_waitrequest,
    output logic [OWNER_W-1:0]   cur_owner,
    output logic                 busy
);

    localparam int c_CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int c_IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_CNT_W-1:0]   r_hold_cnt;
    logic [OWNER_W-1:0]   r_last_owner;
    logic                 r_cs;
    logic                 r_wr_n;
    logic [31:0]          r_wdata;

    logic [6:0]           w_seg [NUM_REQ];
    logic                 w_grant_any;
    logic [OWNER_W-1:0]   w_grant_idx;
    logic [NUM_REQ-1:0]   w_grant_onehot;
    logic [6:0]           w_grant_seg;
    logic [c_IDX_W-1:0]   w_idx;

    // Active-low segments, bit order g f e d c b a
    function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_seg
            assign w_seg[gi] = req_blank[gi] ? 7'h7F : hex_to_seg(req_digit[4*gi +: 4]);
        end
    endgenerate

    // Search starts just after the last owner, so every requester gets a turn
    always_comb begin : arbiter
        w_grant_any    = 1'b0;
        w_grant_idx    = '0;
        w_grant_onehot = '0;
        w_grant_seg    = 7'h7F;
        w_idx          = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = c_IDX_W'((int'(r_last_owner) + k) % NUM_REQ);
            if (!w_grant_any && req_valid[w_idx]) begin
                w_grant_any           = 1'b1;
                w_grant_idx           = OWNER_W'(w_idx);
                w_grant_onehot[w_idx] = 1'b1;
                w_grant_seg           = w_seg[w_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin : next_state
        w_next_state = r_state;
        req_ready    = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = w_grant_onehot;
                if (w_grant_any) begin
                    w_next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!av_waitrequest) begin
                    w_next_state = (HOLD_CYCLES == 0) ? ST_IDLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt <= c_CNT_W'(1)) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_owner <= OWNER_W'(NUM_REQ - 1);
            r_hold_cnt   <= '0;
            r_cs         <= 1'b0;
            r_wr_n       <= 1'b1;
            r_wdata      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_any) begin
                        r_last_owner <= w_grant_idx;
                        r_wdata      <= {25'b0, w_grant_seg};
                        r_cs         <= 1'b1;
                        r_wr_n       <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (!av_waitrequest) begin
                        r_cs       <= 1'b0;
                        r_wr_n     <= 1'b1;
                        r_hold_cnt <= c_CNT_W'(HOLD_CYCLES);
                    end
                end
                ST_HOLD: begin
                    r_hold_cnt <= r_hold_cnt - c_CNT_W'(1);
                end
                default: begin
                    r_cs   <= 1'b0;
                    r_wr_n <= 1'b1;
                end
            endcase
        end
    end

    assign av_address    = 2'b00;
    assign av_chipselect = r_cs;
    assign av_write_n    = r_wr_n;
    assign av_writedata  = r_wdata;
    assign cur_owner     = r_last_owner;
    assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tag_hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tag_hex_display_ctrl
// Brief    : Directed and randomized checks of tag_hex_display_ctrl against a
//            cycle-count reference model of arbitration, encoding and hold.
// Revision : 1.0
// ============================================================================
module tb_tag_hex_display_ctrl;

    localparam int N  = 3;
    localparam int H  = 4;
    localparam int OW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic [N-1:0]    req_valid, req_blank, req_ready;
    logic [4*N-1:0]  req_digit;
    logic [1:0]      av_address;
    logic            av_chipselect, av_write_n, av_waitrequest, busy;
    logic [31:0]     av_writedata;
    logic [OW-1:0]   cur_owner;

    logic [N-1:0]    z_valid, z_blank, z_ready;
    logic [4*N-1:0]  z_digit;
    logic [1:0]      z_address;
    logic            z_cs, z_wr_n, z_wait, z_busy;
    logic [31:0]     z_wdata;
    logic [OW-1:0]   z_owner;

    tag_hex_display_ctrl #(.NUM_REQ(N), .HOLD_CYCLES(H), .OWNER_W(OW)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_digit(req_digit),
        .req_blank(req_blank), .req_ready(req_ready), .av_address(av_address),
        .av_chipselect(av_chipselect), .av_write_n(av_write_n),
        .av_writedata(av_writedata), .av_waitrequest(av_waitrequest),
        .cur_owner(cur_owner), .busy(busy)
    );

    tag_hex_display_ctrl #(.NUM_REQ(N), .HOLD_CYCLES(0), .OWNER_W(OW)) dut_nohold (
        .clk(clk), .reset_n(reset_n), .req_valid(z_valid), .req_digit(z_digit),
        .req_blank(z_blank), .req_ready(z_ready), .av_address(z_address),
        .av_chipselect(z_cs), .av_write_n(z_wr_n), .av_writedata(z_wdata),
        .av_waitrequest(z_wait), .cur_owner(z_owner), .busy(z_busy)
    );

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_cmp = 0;
    int n_err = 0;

    // Requester-side stimulus state
    logic [N-1:0] pend_v, pend_b;
    logic [3:0]   pend_d [N];
    logic         wait_q;

    // Reference model: time-based view of the shared display
    int           cyc;
    int           m_idle_at;
    bit           m_writing;
    int           m_last;
    logic [31:0]  m_wdata;

    int           wlog_t [$];
    logic [31:0]  wlog_d [$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit m_idle();
        return !m_writing && (cyc >= m_idle_at);
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [3:0] d, input logic b);
        return b ? 7'h7F : seg_tab[d];
    endfunction

    // One clock: drive, check the accept, clock, advance model, check bus
    task automatic cycle();
        int g;
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend_v[i];
            req_blank[i]       = pend_b[i];
            req_digit[4*i +: 4] = pend_d[i];
        end
        av_waitrequest = wait_q;
        #1;
        g = m_idle() ? pick(req_valid, m_last) : -1;
        check_eq("ready", {29'b0, req_ready}, (g >= 0) ? (32'd1 << g) : 32'd0);
        if (av_chipselect === 1'b1 && !wait_q) begin
            wlog_t.push_back(cyc);
            wlog_d.push_back(av_writedata);
        end
        @(posedge clk);
        if (g >= 0) begin
            m_last    = g;
            m_wdata   = {25'b0, exp_seg(pend_d[g], pend_b[g])};
            m_writing = 1'b1;
            pend_v[g] = 1'b0;
        end else if (m_writing && !wait_q) begin
            m_writing = 1'b0;
            m_idle_at = cyc + 1 + H;
        end
        cyc++;
        #1;
        check_eq("chipselect", {31'b0, av_chipselect}, {31'b0, m_writing});
        check_eq("write_n", {31'b0, av_write_n}, {31'b0, !m_writing});
        check_eq("address", {30'b0, av_address}, 32'd0);
        if (m_writing) check_eq("writedata", av_writedata, m_wdata);
        check_eq("busy", {31'b0, busy}, {31'b0, !m_idle()});
        check_eq("owner", {30'b0, cur_owner}, m_last);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        pend_v    = '0;
        pend_b    = '0;
        wait_q    = 1'b0;
        req_valid = '0;
        req_blank = '0;
        av_waitrequest = 1'b0;
        m_writing = 1'b0;
        m_last    = N - 1;
        m_wdata   = '0;
        @(posedge clk);
        #1;
        check_eq("rst_cs", {31'b0, av_chipselect}, 32'd0);
        check_eq("rst_wr_n", {31'b0, av_write_n}, 32'd1);
        check_eq("rst_wdata", av_writedata, 32'd0);
        check_eq("rst_ready", {29'b0, req_ready}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_owner", {30'b0, cur_owner}, N - 1);
        reset_n   = 1'b1;
        m_idle_at = cyc;
    endtask

    task automatic idle_wait();
        pend_v = '0;
        wait_q = 1'b0;
        for (int i = 0; i < 20 && !m_idle(); i++) cycle();
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc     = 0;
        reset_n = 1'b0;
        z_valid = '0; z_blank = '0; z_digit = '0; z_wait = 1'b0;
        req_digit = '0;
        for (int i = 0; i < N; i++) pend_d[i] = 4'h0;
        do_reset();

        // Lone request: write next cycle, then H hold cycles
        pend_v = 3'b001; pend_d[0] = 4'h3;
        cycle();
        check_eq("t1_wdata", av_writedata, 32'h30);
        for (int i = 0; i < H + 2; i++) cycle();
        check_eq("t1_idle", {31'b0, busy}, 32'd0);

        // All requesters held valid: rotation 0,1,2,0
        do_reset();
        wlog_t.delete(); wlog_d.delete();
        pend_d[0] = 4'h1; pend_d[1] = 4'h2; pend_d[2] = 4'h3;
        for (int i = 0; i < 20; i++) begin
            pend_v = 3'b111;
            cycle();
        end
        check_eq("t2_nwr", wlog_d.size(), 4);
        if (wlog_d.size() >= 4) begin
            check_eq("t2_w0", wlog_d[0], 32'h79);
            check_eq("t2_w1", wlog_d[1], 32'h24);
            check_eq("t2_w2", wlog_d[2], 32'h30);
            check_eq("t2_w3", wlog_d[3], 32'h79);
            for (int k = 1; k < 4; k++) check_eq("t2_gap", wlog_t[k] - wlog_t[k-1], 6);
        end
        idle_wait();

        // Stalled write: one completion only
        wlog_t.delete(); wlog_d.delete();
        pend_v = 3'b100; pend_d[2] = 4'h0; pend_b = '0;
        cycle();
        wait_q = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        idle_wait();
        check_eq("t3_nwr", wlog_d.size(), 1);
        if (wlog_d.size() == 1) check_eq("t3_wdata", wlog_d[0], 32'h40);

        // Blank overrides the digit
        pend_v = 3'b010; pend_d[1] = 4'h8; pend_b = 3'b010;
        cycle();
        check_eq("t4_blank", av_writedata, 32'h7F);
        pend_b = '0;
        idle_wait();

        // Async reset mid-write, then requester 0 has first priority
        pend_v = 3'b001; pend_d[0] = 4'h5; wait_q = 1'b1;
        cycle();
        cycle();
        #2 reset_n = 1'b0;
        #1;
        check_eq("t5_cs_async", {31'b0, av_chipselect}, 32'd0);
        check_eq("t5_wrn_async", {31'b0, av_write_n}, 32'd1);
        do_reset();
        pend_v = 3'b111; pend_d[0] = 4'h9; pend_d[1] = 4'hA; pend_d[2] = 4'hB;
        cycle();
        check_eq("t5_first", {30'b0, cur_owner}, 32'd0);
        idle_wait();

        // Randomized traffic with random stalls
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend_v[i] && $urandom_range(0, 2) == 0) begin
                    pend_v[i] = 1'b1;
                    pend_d[i] = 4'($urandom_range(0, 15));
                    pend_b[i] = ($urandom_range(0, 7) == 0);
                end else if (pend_v[i] && !m_idle() && $urandom_range(0, 39) == 0) begin
                    pend_v[i] = 1'b0;
                end
            end
            wait_q = ($urandom_range(0, 2) == 0);
            cycle();
        end
        idle_wait();

        // No-hold instance: digit sweep, accept every second cycle
        z_valid = 3'b001;
        for (int k = 0; k < 16; k++) begin
            z_digit[3:0] = 4'(k);
            #1;
            check_eq("t6_ready", {29'b0, z_ready}, 32'd1);
            @(posedge clk);
            #1;
            z_digit[3:0] = 4'(k + 1);
            check_eq("t6_cs", {31'b0, z_cs}, 32'd1);
            check_eq("t6_wdata", z_wdata, {25'b0, seg_tab[k]});
            check_eq("t6_ready_wr", {29'b0, z_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        z_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
